// File: rtl/riscv_pkg.sv
// Shared definitions for the branch resolution slice.
//  - FUNCT3_* : RV32I B-type funct3 encodings
//  - brState_e: branch_resolve FSM states (IDLE accepts, FLUSH kills younger work)
//  - isUnsignedCmp: funct3 selects an unsigned comparison (BLTU/BGEU)
package riscv_pkg;

  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } brState_e;

  // Only the two unsigned branches have funct3[2:1] == 2'b11.
  function automatic logic isUnsignedCmp(input logic [2:0] funct3);
    return funct3[2] & funct3[1];
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition decode.
// Ports:
//  funct3  in  3  B-type funct3
//  BrEq    in  1  comparator: in0 == in1
//  BrLT    in  1  comparator: in0 < in1 (signedness already chosen by BrUn)
//  taken   out 1  branch condition holds
//  illegal out 1  funct3 is not a branch encoding (010/011)
module branch_cond
  import riscv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       BrEq,
  input  logic       BrLT,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      FUNCT3_BEQ:  taken = BrEq;
      FUNCT3_BNE:  taken = ~BrEq;
      FUNCT3_BLT:  taken = BrLT;
      FUNCT3_BGE:  taken = ~BrLT;
      FUNCT3_BLTU: taken = BrLT;
      FUNCT3_BGEU: taken = ~BrLT;
      default:     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution: consumer side of the branch comparator.
// Drives BrUn, decides taken/not-taken from BrEq/BrLT, registers the PC-select
// decision and next PC, sequences a front-end flush after a taken branch and
// keeps saturating taken/total statistics.
// Ports:
//  clk, rst            clock (rising edge), synchronous active-high reset
//  br_valid/br_ready   request handshake
//  br_funct3/pc/imm    branch descriptor
//  BrUn                to comparator: 1 = unsigned compare (combinational)
//  BrEq, BrLT          from comparator, same cycle as the request
//  res_valid           one-cycle result strobe, cycle after accept
//  res_taken/target    decision and next PC (hold between results)
//  PCSel               res_valid & res_taken
//  flush               kill younger instructions (FLUSH state)
//  bad_funct           one-cycle pulse for an accepted illegal funct3
//  taken_cnt/total_cnt saturating statistics
//  dbgState            current FSM state
//
// Handshake: a request transfers on a rising edge where br_valid and br_ready
// are both 1; the requester holds br_valid and the descriptor stable until then,
// and br_ready never depends on br_valid.
module branch_resolve
  import riscv_pkg::*;
#(
  parameter int n            = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_funct3,
  input  logic [n-1:0]     br_pc,
  input  logic [n-1:0]     br_imm,
  output logic             BrUn,
  input  logic             BrEq,
  input  logic             BrLT,
  output logic             res_valid,
  output logic             res_taken,
  output logic [n-1:0]     res_target,
  output logic             PCSel,
  output logic             flush,
  output logic             bad_funct,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] total_cnt,
  output brState_e         dbgState
);

  localparam int CTR_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CTR_W-1:0] FLUSH_LOAD =
    (FLUSH_CYCLES > 0) ? CTR_W'(FLUSH_CYCLES - 1) : '0;

  brState_e         state, nextState;
  logic [CTR_W-1:0] flushCtr, nextFlushCtr;
  logic             accept;
  logic             condTaken;
  logic             condIllegal;
  logic [n-1:0]     nextTarget;

  branch_cond u_cond (
    .funct3  (br_funct3),
    .BrEq    (BrEq),
    .BrLT    (BrLT),
    .taken   (condTaken),
    .illegal (condIllegal)
  );

  assign BrUn       = isUnsignedCmp(br_funct3);
  assign br_ready   = (state == IDLE);
  assign flush      = (state == FLUSH);
  assign accept     = br_valid & br_ready;
  assign PCSel      = res_valid & res_taken;
  assign dbgState   = state;
  // Addition wraps naturally at 2^n.
  assign nextTarget = br_pc + (condTaken ? br_imm : n'(4));

  always_comb begin
    nextState    = state;
    nextFlushCtr = flushCtr;
    case (state)
      IDLE: begin
        if (accept && condTaken && (FLUSH_CYCLES > 0)) begin
          nextState    = FLUSH;
          nextFlushCtr = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        // Counter holds the number of flush cycles still to follow this one.
        if (flushCtr == '0) begin
          nextState = IDLE;
        end else begin
          nextFlushCtr = flushCtr - CTR_W'(1);
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      flushCtr   <= '0;
      res_valid  <= 1'b0;
      res_taken  <= 1'b0;
      res_target <= '0;
      bad_funct  <= 1'b0;
      taken_cnt  <= '0;
      total_cnt  <= '0;
    end else begin
      state     <= nextState;
      flushCtr  <= nextFlushCtr;
      res_valid <= accept;
      bad_funct <= accept & condIllegal;
      if (accept) begin
        res_taken  <= condTaken;
        res_target <= nextTarget;
        if (total_cnt != '1) total_cnt <= total_cnt + CNT_W'(1);
        if (condTaken && (taken_cnt != '1)) taken_cnt <= taken_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;
  import riscv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic        br_valid = 1'b0;
  logic        br_ready, s_br_ready;
  logic [2:0]  br_funct3 = 3'b000;
  logic [31:0] br_pc = '0, br_imm = '0;
  logic        BrUn, s_BrUn;
  logic        BrEq, BrLT;
  logic        res_valid, res_taken, PCSel, flush, bad_funct;
  logic [31:0] res_target;
  logic [15:0] taken_cnt, total_cnt;
  brState_e    dbgState;
  logic        s_res_valid, s_res_taken, s_PCSel, s_flush, s_bad_funct;
  logic [31:0] s_res_target;
  logic [1:0]  s_taken_cnt, s_total_cnt;
  brState_e    s_dbgState;

  // Comparator operands: the bench plays the comparator, answering in the
  // same cycle according to the BrUn the DUT drives.
  logic [31:0] opA = '0, opB = '0;
  always_comb begin
    BrEq = (opA == opB);
    BrLT = BrUn ? (opA < opB) : ($signed(opA) < $signed(opB));
  end

  branch_resolve #(.n(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready),
    .br_funct3(br_funct3), .br_pc(br_pc), .br_imm(br_imm), .BrUn(BrUn),
    .BrEq(BrEq), .BrLT(BrLT), .res_valid(res_valid), .res_taken(res_taken),
    .res_target(res_target), .PCSel(PCSel), .flush(flush), .bad_funct(bad_funct),
    .taken_cnt(taken_cnt), .total_cnt(total_cnt), .dbgState(dbgState)
  );

  // Narrow-counter instance in lockstep with the main DUT (saturation at 3).
  branch_resolve #(.n(32), .FLUSH_CYCLES(2), .CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(s_br_ready),
    .br_funct3(br_funct3), .br_pc(br_pc), .br_imm(br_imm), .BrUn(s_BrUn),
    .BrEq(BrEq), .BrLT(BrLT), .res_valid(s_res_valid), .res_taken(s_res_taken),
    .res_target(s_res_target), .PCSel(s_PCSel), .flush(s_flush), .bad_funct(s_bad_funct),
    .taken_cnt(s_taken_cnt), .total_cnt(s_total_cnt), .dbgState(s_dbgState)
  );

  // ---------------- reference model / scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int accepts  = 0;
  int takens   = 0;
  logic lastTaken = 1'b0;
  logic [31:0] exp_q[$];

  // Branch semantics straight from the ISA definition on the operand values.
  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  function automatic int sat(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; returns #1 after the accepting edge (cycle T+1).
  task automatic send(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] a, input logic [31:0] b);
    int waitCnt;
    logic tk;
    waitCnt = 0;
    br_valid = 1'b1; br_funct3 = f3; br_pc = pc; br_imm = imm; opA = a; opB = b;
    @(negedge clk);
    while (!br_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    n_checks++;
    if (!br_ready) begin
      n_fail++;
      $display("FAIL accept_timeout: br_ready=%0b required 1 after %0d cycles", br_ready, waitCnt);
    end
    @(posedge clk);
    #1;
    br_valid = 1'b0;
    tk = ref_taken(f3, a, b);
    accepts++;
    if (tk) takens++;
    lastTaken = tk;
    exp_q.push_back(tk ? pc + imm : pc + 32'd4);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    br_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
    accepts = 0; takens = 0; lastTaken = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", br_ready); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %0b want 0", res_valid); end
    n_checks++; if (flush !== 1'b0 || PCSel !== 1'b0 || bad_funct !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: flush=%0b PCSel=%0b bad=%0b want 000", flush, PCSel, bad_funct); end
    n_checks++; if (taken_cnt !== 16'd0 || total_cnt !== 16'd0 || s_total_cnt !== 2'd0) begin
      n_fail++; $display("FAIL reset_cnt: taken=%0d total=%0d small=%0d want 0", taken_cnt, total_cnt, s_total_cnt); end
    n_checks++; if (res_target !== 32'd0 || res_taken !== 1'b0 || dbgState !== IDLE) begin
      n_fail++; $display("FAIL reset_regs: target=%h taken=%0b state=%0d want 0", res_target, res_taken, dbgState); end
    @(posedge clk);
    #1 rst = 1'b0;
    accepts = 0; takens = 0; exp_q.delete();
  endtask

  task automatic test_brun();
    logic [2:0] f;
    for (int i = 0; i < 8; i++) begin
      f = 3'(i);
      br_funct3 = f;
      #1;
      n_checks++;
      if (BrUn !== (f == 3'b110 || f == 3'b111)) begin
        n_fail++; $display("FAIL brun_f3_%0d: got %0b want %0b", i, BrUn, (f == 3'b110 || f == 3'b111));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_taken_flush();
    logic [31:0] exp;
    send(3'b000, 32'h100, 32'h20, 32'd5, 32'd5);
    exp = exp_q.pop_front();
    @(negedge clk); // T+1
    n_checks++; if (res_valid !== 1'b1 || res_taken !== 1'b1 || PCSel !== 1'b1) begin
      n_fail++; $display("FAIL beq_result: valid=%0b taken=%0b pcsel=%0b want 111", res_valid, res_taken, PCSel); end
    n_checks++; if (res_target !== exp) begin n_fail++; $display("FAIL beq_target: got %h want %h", res_target, exp); end
    n_checks++; if (flush !== 1'b1 || br_ready !== 1'b0) begin
      n_fail++; $display("FAIL beq_flush1: flush=%0b ready=%0b want 1 0", flush, br_ready); end
    @(negedge clk); // T+2
    n_checks++; if (flush !== 1'b1 || br_ready !== 1'b0 || res_valid !== 1'b0 || PCSel !== 1'b0) begin
      n_fail++; $display("FAIL beq_flush2: flush=%0b ready=%0b valid=%0b pcsel=%0b want 1 0 0 0", flush, br_ready, res_valid, PCSel); end
    n_checks++; if (res_taken !== 1'b1 || res_target !== exp) begin
      n_fail++; $display("FAIL beq_hold: taken=%0b target=%h want 1 %h", res_taken, res_target, exp); end
    @(negedge clk); // T+3
    n_checks++; if (flush !== 1'b0 || br_ready !== 1'b1) begin
      n_fail++; $display("FAIL beq_flush_end: flush=%0b ready=%0b want 0 1", flush, br_ready); end
    n_checks++; if (taken_cnt !== 16'(takens) || total_cnt !== 16'(accepts)) begin
      n_fail++; $display("FAIL beq_cnt: taken=%0d total=%0d want %0d %0d", taken_cnt, total_cnt, takens, accepts); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    int t1;
    // BLTU 5 < 3 unsigned is false -> not taken.
    send(3'b110, 32'h100, 32'h40, 32'd5, 32'd3);
    t1 = cyc;
    exp = exp_q.pop_front();
    n_checks++; if (res_valid !== 1'b1 || res_taken !== 1'b0 || res_target !== exp || flush !== 1'b0) begin
      n_fail++; $display("FAIL bltu_nt: valid=%0b taken=%0b target=%h flush=%0b want 1 0 %h 0", res_valid, res_taken, res_target, flush, exp); end
    // BGEU 5 >= 3 unsigned -> taken, must be accepted on the very next edge.
    send(3'b111, 32'h200, 32'h10, 32'd5, 32'd3);
    exp = exp_q.pop_front();
    n_checks++; if (cyc !== t1 + 1) begin n_fail++; $display("FAIL b2b_accept_cycle: got %0d want %0d", cyc, t1 + 1); end
    n_checks++; if (res_valid !== 1'b1 || res_taken !== 1'b1 || res_target !== exp) begin
      n_fail++; $display("FAIL bgeu_t: valid=%0b taken=%0b target=%h want 1 1 %h", res_valid, res_taken, res_target, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_bge_illegal();
    logic [31:0] exp;
    // Signed 0x80000001 < 1, so BGE is not taken (it would be taken unsigned).
    send(3'b101, 32'h300, 32'h80, 32'h80000001, 32'd1);
    exp = exp_q.pop_front();
    @(negedge clk);
    n_checks++; if (res_taken !== 1'b0 || res_target !== exp || bad_funct !== 1'b0) begin
      n_fail++; $display("FAIL bge_signed: taken=%0b target=%h bad=%0b want 0 %h 0", res_taken, res_target, bad_funct, exp); end
    @(posedge clk); #1;
    send(3'b010, 32'h400, 32'h8, 32'd7, 32'd7);
    exp = exp_q.pop_front();
    @(negedge clk);
    n_checks++; if (bad_funct !== 1'b1 || res_taken !== 1'b0 || res_target !== exp || PCSel !== 1'b0) begin
      n_fail++; $display("FAIL illegal_result: bad=%0b taken=%0b target=%h pcsel=%0b want 1 0 %h 0", bad_funct, res_taken, res_target, PCSel, exp); end
    n_checks++; if (total_cnt !== 16'(accepts) || flush !== 1'b0) begin
      n_fail++; $display("FAIL illegal_total: total=%0d flush=%0b want %0d 0", total_cnt, flush, accepts); end
    @(negedge clk);
    n_checks++; if (bad_funct !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse: bad=%0b want 0", bad_funct); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    send(3'b001, 32'hFFFFFFFC, 32'h100, 32'd9, 32'd9);
    exp = exp_q.pop_front();
    n_checks++; if (res_target !== 32'h0 || exp !== 32'h0) begin
      n_fail++; $display("FAIL wrap_nt: target=%h want 00000000", res_target); end
    @(posedge clk); #1;
    send(3'b000, 32'hFFFFFFFC, 32'h8, 32'd9, 32'd9);
    exp = exp_q.pop_front();
    n_checks++; if (res_target !== 32'h4 || res_taken !== 1'b1) begin
      n_fail++; $display("FAIL wrap_t: target=%h taken=%0b want 00000004 1", res_target, res_taken); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_flush();
    void'(exp_q.size());
    send(3'b001, 32'h500, 32'h40, 32'd1, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL rst_flush_pre: flush=%0b want 1", flush); end
    @(posedge clk);
    #1 rst = 1'b0;
    accepts = 0; takens = 0; exp_q.delete();
    @(negedge clk);
    n_checks++; if (flush !== 1'b0 || br_ready !== 1'b1 || res_valid !== 1'b0 || PCSel !== 1'b0 || dbgState !== IDLE) begin
      n_fail++; $display("FAIL rst_mid_flush: flush=%0b ready=%0b valid=%0b pcsel=%0b state=%0d want 0 1 0 0 0",
                         flush, br_ready, res_valid, PCSel, dbgState); end
    n_checks++; if (taken_cnt !== 16'd0 || total_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rst_mid_cnt: taken=%0d total=%0d want 0 0", taken_cnt, total_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      send(3'b001, 32'h600 + 32'(i * 4), 32'h10, 32'd3, 32'd3);
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    n_checks++; if (s_total_cnt !== 2'(sat(accepts, 2)) || total_cnt !== 16'(sat(accepts, 16))) begin
      n_fail++; $display("FAIL sat_total: small=%0d big=%0d want %0d %0d", s_total_cnt, total_cnt, sat(accepts, 2), sat(accepts, 16)); end
    n_checks++; if (s_taken_cnt !== 2'd0) begin n_fail++; $display("FAIL sat_taken_small: got %0d want 0", s_taken_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] pc, imm, a, b, exp;
    logic        tk;
    for (int i = 0; i < 60; i++) begin
      f3  = 3'($urandom_range(0, 7));
      pc  = $urandom & 32'hFFFFFFFC;
      imm = ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFFFFFE) : 32'($urandom_range(0, 255) * 2);
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ 32'h80000000;
        default: b = $urandom;
      endcase
      send(f3, pc, imm, a, b);
      tk  = lastTaken;
      exp = exp_q.pop_front();
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1 || res_taken !== tk || res_target !== exp || PCSel !== tk ||
          bad_funct !== ref_illegal(f3) || flush !== tk) begin
        n_fail++;
        $display("FAIL rand_%0d f3=%0d: valid=%0b taken=%0b target=%h pcsel=%0b bad=%0b flush=%0b want 1 %0b %h %0b %0b %0b",
                 i, f3, res_valid, res_taken, res_target, PCSel, bad_funct, flush, tk, exp, tk, ref_illegal(f3), tk);
      end
      n_checks++;
      if (total_cnt !== 16'(sat(accepts, 16)) || taken_cnt !== 16'(sat(takens, 16)) ||
          s_total_cnt !== 2'(sat(accepts, 2)) || s_taken_cnt !== 2'(sat(takens, 2))) begin
        n_fail++;
        $display("FAIL rand_cnt_%0d: total=%0d taken=%0d s_total=%0d s_taken=%0d want %0d %0d %0d %0d",
                 i, total_cnt, taken_cnt, s_total_cnt, s_taken_cnt,
                 sat(accepts, 16), sat(takens, 16), sat(accepts, 2), sat(takens, 2));
      end
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_brun();
    test_taken_flush();
    test_back_to_back();
    test_bge_illegal();
    test_wrap();
    test_reset_mid_flush();
    test_saturation();
    test_random();
    do_reset(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
